fir_tdm: RTL and testbench
==========================

FIR_TDM -- requirements
Module: fir_tdm

Interface
REQ-001 Parameter IPL, default 4: input sample width, signed two's complement.
REQ-002 Parameter CEL, default 4: coefficient width, signed two's complement.
REQ-003 Parameter OPL, default 6: output sample width, signed two's complement.
REQ-004 Parameter IPD, default 5: number of filter taps, minimum 2.
REQ-005 Parameter NCH, default 2: number of independent channels, minimum 1.
REQ-006 Parameter SHIFT, default 0: arithmetic right shift applied to the accumulator before saturation.
REQ-007 Port clk, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-008 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port in_valid, input, 1 bit: input sample offered.
REQ-010 Port in_ready, output, 1 bit: block can accept a sample.
REQ-011 Port in_ch, input, clog2(NCH) bits (min 1): channel tag of the offered sample.
REQ-012 Port X, input, IPL bits: offered sample.
REQ-013 Port out_valid, output, 1 bit: result available.
REQ-014 Port out_ready, input, 1 bit: consumer accepts the result.
REQ-015 Port out_ch, output, clog2(NCH) bits: channel tag of the result.
REQ-016 Port Y, output, OPL bits: filtered, saturated result.
REQ-017 Port coef_we, input, 1 bit: write one shadow coefficient.
REQ-018 Port coef_addr, input, clog2(IPD) bits: tap index; addresses >= IPD ignored.
REQ-019 Port coef_data, input, CEL bits: coefficient value.
REQ-020 Port coef_commit, input, 1 bit: request shadow-to-active bank copy.

Function
REQ-021 Input handshake: sample accepted on an edge where in_valid and in_ready are both high; output handshake: result consumed on an edge where out_valid and out_ready are both high.
REQ-022 Per-channel delay line of IPD samples; on acceptance, the sample shifts into tap 0 of channel in_ch only; other channels unchanged.
REQ-023 FSM states IDLE, MAC, HOLD; in_ready high only in IDLE; out_valid high only in HOLD.
REQ-024 IDLE -> MAC on acceptance (edge T); MAC lasts exactly IPD cycles (T+1..T+IPD), one tap multiply-accumulated per cycle, tap k using active coefficient k.
REQ-025 MAC -> HOLD after last tap; out_valid rises at T+IPD+1; Y and out_ch stay stable until the output handshake.
REQ-026 HOLD -> IDLE on output handshake; in_ready high the following cycle; peak throughput one sample per IPD+2 cycles.
REQ-027 Accumulator width IPL+CEL+clog2(IPD), signed, full precision, no intermediate overflow.
REQ-028 Y = accumulator arithmetically shifted right by SHIFT (truncation toward minus infinity), saturated to [-2^(OPL-1), 2^(OPL-1)-1].
REQ-029 coef_we writes the shadow bank in any state; a write and commit in the same cycle commits the new value.
REQ-030 coef_commit latches a pending flag; copy shadow to active occurs on the first edge in IDLE with no simultaneous acceptance, then clears the flag; the active bank never changes during MAC or HOLD.
REQ-031 If acceptance and a pending commit coincide in IDLE, the sample is processed with the old bank and the copy occurs on return to IDLE.
REQ-032 out_ready asserted outside HOLD has no effect; in_valid outside IDLE is ignored, not queued.

Reset
REQ-033 rst asynchronously forces state IDLE, in_ready 0 while asserted then 1 on the first cycle after release, out_valid 0, Y 0, out_ch 0, accumulator 0, commit flag 0.
REQ-034 rst clears all delay lines and both coefficient banks to 0; reset mid-MAC or mid-HOLD discards the result.

Structure
REQ-035 Shared package fir_pkg holds the FSM state encoding, the clog2 function and accumulator-width/saturation-limit constants.
REQ-036 One sub-module, fir_sat, performs shift and saturation combinationally; the MAC, FSM, delay lines and banks stay in fir_tdm.

Verification (IPL=4, CEL=4, OPL=6, IPD=5, NCH=2, SHIFT=0)
REQ-037 All coefficients 1, commit; ch0 samples 3,4,5 with out_ready high -> Y 3,7,12, each out_valid exactly 6 cycles after acceptance.
REQ-038 Coefficients 1; ch0=3, ch1=5, ch0=4 -> Y 3 (ch0), 5 (ch1), 7 (ch0).
REQ-039 All coefficients 7; ch0 fed 7 five times -> final Y 31 (saturated from 245); then 5x -8 on ch1 -> final Y -32.
REQ-040 out_ready low 10 cycles during HOLD -> Y, out_ch, out_valid held, in_ready 0 throughout; in_ready 1 the cycle after handshake.
REQ-041 Coefficients 1 active; write shadow all 2 and commit during MAC -> current result uses 1s, next sample uses 2s.
REQ-042 rst pulsed during MAC -> out_valid 0, in_ready 1 after release, next ch0=3 with coefficients reloaded to 1 -> Y 3.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR: FSM encoding, width helpers
// and the accumulator/saturation constants for the default configuration.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_HOLD = 2'd2
  } fir_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Port/index widths never collapse to zero bits.
  function automatic int clog2_min1(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int acc_width(input int ipl, input int cel, input int ipd);
    return ipl + cel + clog2(ipd);
  endfunction

  localparam int ACC_W_DEF   = acc_width(4, 4, 5);
  localparam int SAT_MAX_DEF = (1 << (6 - 1)) - 1;
  localparam int SAT_MIN_DEF = -(1 << (6 - 1));

endpackage

// File: rtl/fir_sat.sv
// Arithmetic right shift of the accumulator followed by saturation to the
// signed output range. Purely combinational.
module fir_sat
  import fir_pkg::*;
#(
  parameter int AW    = ACC_W_DEF,
  parameter int OPL   = 6,
  parameter int SHIFT = 0
) (
  input  logic signed [AW-1:0]  i_acc,
  output logic signed [OPL-1:0] o_y
);

  // One spare bit so both limits are representable whatever AW is.
  localparam int CW = ((AW > OPL) ? AW : OPL) + 1;

  localparam logic signed [CW-1:0] SAT_HI = {{(CW-OPL+1){1'b0}}, {(OPL-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_LO = {{(CW-OPL+1){1'b1}}, {(OPL-1){1'b0}}};

  logic signed [AW-1:0] w_shifted;
  logic signed [CW-1:0] w_ext;

  assign w_shifted = i_acc >>> SHIFT;
  assign w_ext     = CW'(w_shifted);

  always_comb begin
    o_y = w_ext[OPL-1:0];
    if (w_ext > SAT_HI) begin
      o_y = SAT_HI[OPL-1:0];
    end else if (w_ext < SAT_LO) begin
      o_y = SAT_LO[OPL-1:0];
    end
  end

endmodule

// File: rtl/fir_tdm.sv
// Multi-channel FIR sharing one multiplier: one tap per cycle, per-channel
// delay lines, double-buffered coefficients swapped only while idle.
module fir_tdm
  import fir_pkg::*;
#(
  parameter int IPL   = 4,
  parameter int CEL   = 4,
  parameter int OPL   = 6,
  parameter int IPD   = 5,
  parameter int NCH   = 2,
  parameter int SHIFT = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [clog2_min1(NCH)-1:0]    in_ch,
  input  logic [IPL-1:0]                X,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [clog2_min1(NCH)-1:0]    out_ch,
  output logic [OPL-1:0]                Y,
  input  logic                          coef_we,
  input  logic [clog2_min1(IPD)-1:0]    coef_addr,
  input  logic [CEL-1:0]                coef_data,
  input  logic                          coef_commit
);

  localparam int CHW = clog2_min1(NCH);
  localparam int TW  = clog2_min1(IPD);
  localparam int AW  = acc_width(IPL, CEL, IPD);

  fir_state_t r_state;
  fir_state_t w_state_next;

  logic [TW-1:0]          r_tap;
  logic [CHW-1:0]         r_ch;
  logic signed [AW-1:0]   r_acc;
  logic                   r_pend;
  logic [OPL-1:0]         r_y;
  logic [CHW-1:0]         r_och;
  logic signed [CEL-1:0]  r_shadow [IPD];
  logic signed [CEL-1:0]  r_active [IPD];

  logic                   w_accept;
  logic                   w_last;
  logic                   w_copy;
  logic signed [IPL-1:0]  w_tap_by_ch [NCH];
  logic signed [IPL-1:0]  w_tap;
  logic signed [CEL-1:0]  w_coef;
  logic signed [IPL+CEL-1:0] w_prod;
  logic signed [AW-1:0]   w_acc_next;
  logic signed [OPL-1:0]  w_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = ~rst;
        w_accept = in_valid & ~rst;
        if (w_accept) w_state_next = ST_MAC;
      end
      ST_MAC: begin
        w_last = (r_tap == TW'(IPD - 1));
        if (w_last) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A pending bank swap waits for an idle edge that does not start a new sample.
  assign w_copy = r_pend && (r_state == ST_IDLE) && !w_accept;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic signed [IPL-1:0] r_taps [IPD];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < IPD; k++) r_taps[k] <= '0;
        end else if (w_accept && (in_ch == CHW'(gi))) begin
          r_taps[0] <= X;
          for (int k = 1; k < IPD; k++) r_taps[k] <= r_taps[k-1];
        end
      end

      assign w_tap_by_ch[gi] = r_taps[r_tap];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < IPD; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      if (coef_we && (int'(coef_addr) < IPD)) r_shadow[coef_addr] <= coef_data;
      if (w_copy) r_active <= r_shadow;
    end
  end

  assign w_tap      = w_tap_by_ch[r_ch];
  assign w_coef     = r_active[r_tap];
  assign w_prod     = w_tap * w_coef;
  assign w_acc_next = r_acc + AW'(w_prod);

  fir_sat #(
    .AW    (AW),
    .OPL   (OPL),
    .SHIFT (SHIFT)
  ) u_sat (
    .i_acc (w_acc_next),
    .o_y   (w_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_tap  <= '0;
      r_ch   <= '0;
      r_y    <= '0;
      r_och  <= '0;
      r_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= '0;
        r_tap <= '0;
        r_ch  <= in_ch;
      end else if (r_state == ST_MAC) begin
        r_acc <= w_acc_next;
        r_tap <= r_tap + TW'(1);
        if (w_last) begin
          r_y   <= w_sat;
          r_och <= r_ch;
        end
      end
      if (coef_commit) begin
        r_pend <= 1'b1;
      end else if (w_copy) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign Y      = r_y;
  assign out_ch = r_och;

endmodule

// File: tb/tb_fir_tdm.sv
// Scoreboard bench for fir_tdm: a reference model predicts each result when the
// sample is accepted; the output monitor pops and compares on every handshake.
module tb_fir_tdm;

  localparam int IPL = 4, CEL = 4, OPL = 6, IPD = 5, NCH = 2, SHIFT = 0;
  localparam int CHW = 1, TW = 3, LAT = IPD + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [CHW-1:0] in_ch = '0;
  logic [IPL-1:0] X = '0;
  logic out_valid, out_ready = 1'b1;
  logic [CHW-1:0] out_ch;
  logic [OPL-1:0] Y;
  logic coef_we = 1'b0, coef_commit = 1'b0;
  logic [TW-1:0] coef_addr = '0;
  logic [CEL-1:0] coef_data = '0;

  fir_tdm #(.IPL(IPL), .CEL(CEL), .OPL(OPL), .IPD(IPD), .NCH(NCH), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .X(X),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .Y(Y),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit)
  );

  always #5 clk = ~clk;

  typedef struct { int y; int ch; int acc_cyc; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int mdl_dl [NCH][IPD];
  int mdl_cf [IPD];
  int mdl_sh [IPD];
  int acc_cyc_last = 0;
  bit prev_ov = 1'b0;
  bit rnd_or = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int mdl_result(input int ch);
    int s;
    s = 0;
    for (int k = 0; k < IPD; k++) s += mdl_dl[ch][k] * mdl_cf[k];
    s = s >>> SHIFT;
    if (s > (1 << (OPL-1)) - 1) s = (1 << (OPL-1)) - 1;
    if (s < -(1 << (OPL-1))) s = -(1 << (OPL-1));
    return s;
  endfunction

  task automatic mdl_clear();
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < IPD; k++) mdl_dl[c][k] = 0;
    for (int k = 0; k < IPD; k++) begin
      mdl_cf[k] = 0;
      mdl_sh[k] = 0;
    end
  endtask

  task automatic apply_model_bank();
    for (int k = 0; k < IPD; k++) mdl_cf[k] = mdl_sh[k];
  endtask

  // Output monitor: latency on the rising edge of out_valid, data on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (exp_q.size() == 0) check_val("spurious_valid", 1, 0);
        else check_val("latency", cyc - exp_q[0].acc_cyc, LAT);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("OUT  ch=%0d y=%0d (expected ch=%0d y=%0d)", out_ch, $signed(Y), e.ch, e.y);
          check_val("y", int'($signed(Y)), e.y);
          check_val("out_ch", int'(out_ch), e.ch);
        end
      end
      prev_ov = out_valid;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rnd_or) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b0;
    coef_we = 1'b0;
    coef_commit = 1'b0;
    #1;
    check_val("rst_in_ready", int'(in_ready), 0);
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_y", int'(Y), 0);
    check_val("rst_out_ch", int'(out_ch), 0);
    mdl_clear();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rel_in_ready", int'(in_ready), 1);
    check_val("rel_out_valid", int'(out_valid), 0);
  endtask

  // Coefficient k = base + step*k, plus ignored writes to addresses >= IPD.
  task automatic load(input int base, input int step, input bit commit);
    for (int k = 0; k < (1 << TW); k++) begin
      int v;
      logic signed [CEL-1:0] vv;
      v = (k < IPD) ? base + step * k : -1;
      vv = v[CEL-1:0];
      @(posedge clk);
      #1 coef_we = 1'b1;
      coef_addr = TW'(k);
      coef_data = vv;
      if (k < IPD) mdl_sh[k] = int'(vv);
    end
    @(posedge clk);
    #1 coef_we = 1'b0;
    coef_commit = commit;
    @(posedge clk);
    #1 coef_commit = 1'b0;
  endtask

  task automatic send(input int ch, input int x, input int gap, input bit with_commit);
    bit ok;
    exp_t e;
    @(posedge clk);
    #1;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_ch = CHW'(ch);
    X = x[IPL-1:0];
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_val("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (with_commit) coef_commit = 1'b1;
    for (int k = IPD - 1; k > 0; k--) mdl_dl[ch][k] = mdl_dl[ch][k-1];
    mdl_dl[ch][0] = x;
    e.y = mdl_result(ch);
    e.ch = ch;
    e.acc_cyc = cyc;
    acc_cyc_last = cyc;
    exp_q.push_back(e);
    $display("SEND ch=%0d x=%0d expect y=%0d", ch, x, e.y);
    @(posedge clk);
    #1 in_valid = 1'b0;
    coef_commit = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val("drain_timeout", 0, 1);
  endtask

  initial begin
    int a0;
    int a1;
    bit seen;

    // Basic accumulation and back-to-back throughput on one channel.
    do_reset();
    load(1, 0, 1'b1);
    apply_model_bank();
    send(0, 3, 0, 1'b0);
    a0 = acc_cyc_last;
    send(0, 4, 0, 1'b0);
    a1 = acc_cyc_last;
    check_val("throughput1", a1 - a0, IPD + 2);
    send(0, 5, 0, 1'b0);
    check_val("throughput2", acc_cyc_last - a1, IPD + 2);
    drain();

    // Channels keep independent delay lines.
    do_reset();
    load(1, 0, 1'b1);
    apply_model_bank();
    send(0, 3, 0, 1'b0);
    send(1, 5, 0, 1'b0);
    send(0, 4, 0, 1'b0);
    drain();

    // Positive and negative saturation.
    do_reset();
    load(7, 0, 1'b1);
    apply_model_bank();
    for (int i = 0; i < 5; i++) send(0, 7, 0, 1'b0);
    for (int i = 0; i < 5; i++) send(1, -8, 0, 1'b0);
    drain();

    // Back-pressure in HOLD; in_valid offered meanwhile must be dropped.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(1, 2, 0, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("hold_reached", int'(seen), 1);
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_ch = '0;
    X = 4'd5;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check_val("hold_out_valid", int'(out_valid), 1);
      check_val("hold_in_ready", int'(in_ready), 0);
      if (exp_q.size() == 0) begin
        check_val("hold_queue", 0, 1);
      end else begin
        check_val("hold_y", int'($signed(Y)), exp_q[0].y);
        check_val("hold_out_ch", int'(out_ch), exp_q[0].ch);
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("hs_in_ready", int'(in_ready), 0);
    @(negedge clk);
    check_val("post_hs_in_ready", int'(in_ready), 1);
    send(0, 1, 0, 1'b0);
    drain();

    // Commit during MAC takes effect only for the next sample.
    do_reset();
    load(1, 0, 1'b1);
    apply_model_bank();
    send(0, 2, 0, 1'b0);
    load(2, 0, 1'b1);
    drain();
    apply_model_bank();
    send(0, 1, 0, 1'b0);
    drain();

    // Commit coinciding with acceptance: old bank now, new bank next.
    load(3, 0, 1'b0);
    send(0, 1, 0, 1'b1);
    drain();
    apply_model_bank();
    send(0, 2, 0, 1'b0);
    drain();

    // Distinct per-tap coefficients, then random traffic under random back-pressure.
    do_reset();
    load(-2, 1, 1'b1);
    apply_model_bank();
    send(0, 7, 0, 1'b0);
    send(1, -3, 0, 1'b0);
    send(0, -8, 0, 1'b0);
    send(0, 5, 0, 1'b0);
    send(1, 6, 0, 1'b0);
    send(0, 1, 0, 1'b0);
    drain();
    load(3, -2, 1'b1);
    apply_model_bank();
    @(posedge clk);
    #1 rnd_or = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 2)), 1'b0);
    end
    drain();
    @(posedge clk);
    #1 rnd_or = 1'b0;
    out_ready = 1'b1;

    // Reset during MAC discards the result and clears banks and delay lines.
    do_reset();
    load(1, 0, 1'b1);
    apply_model_bank();
    send(0, 3, 0, 1'b0);
    do_reset();
    load(1, 0, 1'b1);
    apply_model_bank();
    send(0, 3, 0, 1'b0);
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
